keypad_conditioner: RTL
=======================

KEYPAD_CONDITIONER -- requirements
Module: keypad_conditioner

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset, with ports as follows.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- pb_raw  input  15  asynchronous pushbutton levels:
  - [12:0] note keys, low C to high C;
  - [13] mode button;
  - [14] sound button.
- pb  output  15  debounced button levels; bit mapping identical to pb_raw.
- keys  output  13  conditioned note-key vector for the keypad encoder.
- mode_edge  output  1  one-cycle pulse on debounced rising edge of pb[13].
- sound_edge  output  1  one-cycle pulse on debounced rising edge of pb[14].
- tick  output  1  debounce sample strobe, exported for test.

REQ-002 The module SHALL have the following parameters (name, default, meaning).
- TICK_DIV, 1000, clk cycles per sample tick; legal range 2..65535.
- DB_COUNT, 4, consecutive disagreeing ticks required to flip a debounced level; legal range 1..15.

Function
REQ-003 Each pb_raw bit SHALL pass through a 2-flop synchronizer before any other use; the synchronizer output is called sync[i].
REQ-004 A free-running tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be 1 exactly in the cycle the counter equals TICK_DIV-1.
REQ-005 Per bit, on a tick with sync[i] != pb[i]: cnt[i] SHALL increment; when cnt[i] already equals DB_COUNT-1, pb[i] SHALL toggle and cnt[i] SHALL clear.
REQ-006 Per bit, on a tick with sync[i] == pb[i], cnt[i] SHALL clear, so any glitch shorter than DB_COUNT ticks is rejected.
REQ-007 Between ticks, cnt[i] and pb[i] SHALL hold.
REQ-008 mode_edge SHALL be 1 for exactly the one cycle after pb[13] goes 0->1; sound_edge likewise for pb[14]. Falling edges SHALL produce no pulse.
REQ-009 Simultaneous edges on several bits SHALL be handled independently. mode_edge and sound_edge MAY pulse in the same cycle.
REQ-010 Without the configured feature, keys SHALL equal pb[12:0] combinationally. Multiple pressed keys SHALL pass through unchanged; priority is resolved downstream.
REQ-011 Worst-case press latency from a pb_raw edge to pb SHALL be 2 + DB_COUNT*TICK_DIV cycles. The edge pulse SHALL follow one cycle later.

Reset
REQ-012 While rst=1 at a clock edge, the following SHALL be cleared: synchronizer flops, tick counter, all cnt[i], pb, keys (and any hold register), mode_edge, sound_edge, and tick.
REQ-013 Reset asserted mid-debounce SHALL discard the partial count. A button still held after reset SHALL then require a full DB_COUNT ticks and SHALL produce an edge pulse.

Configuration
REQ-014 With KEYPAD_NOTE_HOLD_EN defined, a 13-bit hold register SHALL drive keys.
- It SHALL load pb[12:0] whenever pb[12:0] is nonzero and differs from the register.
- It SHALL retain its value when pb[12:0] becomes all-zero.
- Only reset SHALL clear it.
REQ-015 With KEYPAD_NOTE_HOLD_EN undefined, no hold register SHALL exist and REQ-010 SHALL apply.

Structure
REQ-016 A shared package keypad_pkg SHALL hold the following:
- NUM_KEYS=13, NUM_PB=15, MODE_IDX=13, SOUND_IDX=14;
- a typedef for the 13-bit key vector.
REQ-017 One sub-module, button_debouncer, SHALL implement the synchronizer, cnt and debounced level for a single bit. It SHALL be instantiated NUM_PB times sharing the tick.

Verification (TICK_DIV=4, DB_COUNT=3)
REQ-018 Hold pb_raw[0]=1 steady -> pb[0]=1 within 2+12 cycles and keys=13'h0001; pb[0] stays 0 before the third qualifying tick.
REQ-019 Pulse pb_raw[5]=1 for 6 cycles, then 0 -> pb[5] never rises; cnt clears; keys stays 0.
REQ-020 Hold pb_raw[13] and pb_raw[14] high together -> mode_edge and sound_edge each pulse once, in the same cycle; no pulse on release.
REQ-021 Assert rst for 1 cycle while pb_raw[2] is held and mid-count -> all outputs 0 next cycle; pb[2] re-qualifies after a full 3 ticks.
REQ-022 With KEYPAD_NOTE_HOLD_EN: press then release key 7 -> keys stays 13'h0080. Then press key 9 -> keys becomes 13'h0200.
REQ-023 Drive pb_raw=15'h7FFF, then 0 -> all pb bits rise on the same tick and fall on the same tick; tick period measures exactly 4 cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad conditioner.
// Bit layout: [12:0] note keys, [13] mode, [14] sound.
package keypad_pkg;
  localparam int NUM_KEYS  = 13;
  localparam int NUM_PB    = 15;
  localparam int MODE_IDX  = 13;
  localparam int SOUND_IDX = 14;

  typedef logic [NUM_KEYS-1:0] key_vec_t;
endpackage

// File: rtl/button_debouncer.sv
// One-bit synchronizer plus tick-sampled debounce counter.
// Level flips after DB_COUNT consecutive disagreeing ticks.
module button_debouncer #(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level
);
  localparam logic [3:0] CNT_MAX = 4'(DB_COUNT - 1);

  logic       s1_q;
  logic       sync_q;
  logic       lvl_q, lvl_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (tick) begin
      if (sync_q == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      s1_q   <= raw;
      sync_q <= s1_q;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  assign level = lvl_q;
endmodule

// File: rtl/keypad_conditioner.sv
// Debounces 15 pushbuttons, emits mode/sound rising-edge pulses.
// Define KEYPAD_NOTE_HOLD_EN to latch the last nonzero note-key set.
module keypad_conditioner
  import keypad_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DB_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb,
  output key_vec_t          keys,
  output logic              mode_edge,
  output logic              sound_edge,
  output logic              tick
);
  localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);

  logic [15:0]       tcnt_q, tcnt_d;
  logic [NUM_PB-1:0] pb_dly_q;
  logic              mode_edge_q, mode_edge_d;
  logic              sound_edge_q, sound_edge_d;

  assign tick = (tcnt_q == TICK_MAX);

  always_comb begin
    tcnt_d       = tick ? '0 : tcnt_q + 16'd1;
    mode_edge_d  = pb[MODE_IDX] & ~pb_dly_q[MODE_IDX];
    sound_edge_d = pb[SOUND_IDX] & ~pb_dly_q[SOUND_IDX];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q       <= '0;
      pb_dly_q     <= '0;
      mode_edge_q  <= 1'b0;
      sound_edge_q <= 1'b0;
    end else begin
      tcnt_q       <= tcnt_d;
      pb_dly_q     <= pb;
      mode_edge_q  <= mode_edge_d;
      sound_edge_q <= sound_edge_d;
    end
  end

  assign mode_edge  = mode_edge_q;
  assign sound_edge = sound_edge_q;

  for (genvar i = 0; i < NUM_PB; i++) begin : g_db
    button_debouncer #(.DB_COUNT(DB_COUNT)) u_db (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (pb_raw[i]),
      .level(pb[i])
    );
  end

`ifdef KEYPAD_NOTE_HOLD_EN
  key_vec_t hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (pb[NUM_KEYS-1:0] != '0 && pb[NUM_KEYS-1:0] != hold_q)
      hold_d = pb[NUM_KEYS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign keys = hold_q;
`else
  assign keys = pb[NUM_KEYS-1:0];
`endif
endmodule
